// File: rtl/fifo_pkg.sv
// Shared sizing constants and types for the 16 x 8 FIFO slice.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH     = 8;
  localparam int unsigned FIFO_DEPTH     = 16;
  localparam int unsigned FIFO_ADDR_SIZE = 4;

  // One stored data word.
  typedef logic [FIFO_WIDTH-1:0] word_t;

  // Read/write pointer: index bits plus one wrap bit above them.
  typedef logic [FIFO_ADDR_SIZE:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one synchronous read
// port whose output register is cleared by reset (the array itself is not).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned width     = FIFO_WIDTH,
  parameter int unsigned depth     = FIFO_DEPTH,
  parameter int unsigned addr_size = FIFO_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [addr_size-1:0] wr_addr,
  input  logic [width-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [addr_size-1:0] rd_addr,
  output logic [width-1:0]     rd_data
);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [width-1:0] rd_data_q;
  logic [width-1:0] rd_data_d;

  // Next array contents: only the addressed word changes on a write.
  always_comb begin
    for (int unsigned i = 0; i < depth; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage array; deliberately has no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < depth; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Next read register: load the addressed word on a read, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Read output register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : fifo_mem

// File: rtl/fifo_16_8.sv
// Single-clock FIFO, 16 x 8, registered read data, empty/full flags derived
// from wrap-bit pointers.
module fifo_16_8
  import fifo_pkg::*;
#(
  parameter int unsigned width     = FIFO_WIDTH,
  parameter int unsigned depth     = FIFO_DEPTH,
  parameter int unsigned addr_size = FIFO_ADDR_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [width-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam logic [addr_size:0] PtrOne = {{addr_size{1'b0}}, 1'b1};

  logic [addr_size:0] wr_ptr_q;
  logic [addr_size:0] wr_ptr_d;
  logic [addr_size:0] rd_ptr_q;
  logic [addr_size:0] rd_ptr_d;
  logic               wr_accept;
  logic               rd_accept;

  // Status flags straight from the pointers; equal index bits with differing
  // wrap bits means the writer is a full lap ahead.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[addr_size] != rd_ptr_q[addr_size]) &&
            (wr_ptr_q[addr_size-1:0] == rd_ptr_q[addr_size-1:0]);
  end

  // Accept decisions and pointer advance, each side judged on current flags
  // only, so an empty FIFO never forwards a same-cycle write to the output.
  always_comb begin
    wr_accept = wr_en && !full;
    rd_accept = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  // Pointer registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_mem #(
    .width     (width),
    .depth     (depth),
    .addr_size (addr_size)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[addr_size-1:0]),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q[addr_size-1:0]),
    .rd_data (data_out)
  );

endmodule : fifo_16_8

// File: tb/tb_fifo_16_8.sv
// Directed bench for fifo_16_8: table of fill/drain vectors plus hand-written
// reset, simultaneous-access and wrap-around sequences.
module tb_fifo_16_8;
  import fifo_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  word_t data_in;
  logic  wr_en;
  logic  rd_en;
  word_t data_out;
  logic  empty;
  logic  full;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  typedef struct {
    logic  wr;
    logic  rd;
    word_t din;
    word_t exp_dout;
    logic  exp_empty;
    logic  exp_full;
  } vec_t;

  vec_t vecs[$];

  fifo_16_8 #(
    .width     (FIFO_WIDTH),
    .depth     (FIFO_DEPTH),
    .addr_size (FIFO_ADDR_SIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input word_t d, input logic e, input logic f);
    chk({name, ".data_out"}, int'(data_out), int'(d));
    chk({name, ".empty"}, int'(empty), int'(e));
    chk({name, ".full"}, int'(full), int'(f));
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit past the rising edge.
  task automatic step(input logic w, input logic r, input word_t d);
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

    // Build the fill / overflow / held-drain table.
    for (int i = 1; i <= 16; i++)
      vecs.push_back('{1'b1, 1'b0, word_t'(100 + i), 8'd0, 1'b0, (i == 16)});
    vecs.push_back('{1'b1, 1'b0, 8'd200, 8'd0, 1'b0, 1'b1});
    for (int i = 1; i <= 16; i++)
      vecs.push_back('{1'b0, 1'b1, 8'd0, word_t'(100 + i), (i == 16), 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'd0, 8'd116, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'd0, 8'd116, 1'b1, 1'b0});

    // Reset held for one cycle, then released.
    @(posedge clk); #1;
    chk_all("reset_held", 8'd0, 1'b1, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_all("reset_release", 8'd0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_empty, vecs[i].exp_full);
    end

    // Mid-operation asynchronous reset with 5 entries stored.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, word_t'(151 + i));
    step(1'b0, 1'b1, 8'd0);
    chk_all("pre_reset_read", 8'd151, 1'b0, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all("async_reset", 8'd0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    step(1'b1, 1'b0, 8'd160);
    chk_all("post_reset_write", 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd0);
    chk_all("post_reset_read", 8'd160, 1'b1, 1'b0);

    // Simultaneous access with 3 entries: occupancy unchanged.
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, word_t'(i));
    step(1'b1, 1'b1, 8'd4);
    chk_all("simul_mid", 8'd1, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 1'b1, 8'd0);
      chk_all($sformatf("simul_mid_drain%0d", i), word_t'(i), (i == 4), 1'b0);
    end

    // Simultaneous access at empty: write only, no bypass.
    step(1'b1, 1'b1, 8'd50);
    chk_all("simul_empty", 8'd4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd0);
    chk_all("simul_empty_read", 8'd50, 1'b1, 1'b0);

    // Simultaneous access at full: read only, 99 must not be stored.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, word_t'(60 + i));
    chk_all("full_again", 8'd50, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'd99);
    chk_all("simul_full", 8'd60, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1, 8'd0);
      chk_all($sformatf("simul_full_drain%0d", i), word_t'(60 + i), (i == 15), 1'b0);
    end

    // Wrap-around: three passes of 10 entries cross the index-15 boundary.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, word_t'(10 + 20 * p + k));
      chk_all($sformatf("wrap%0d_filled", p), (p == 0) ? 8'd75 : word_t'(10 + 20 * (p - 1) + 9), 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
        step(1'b0, 1'b1, 8'd0);
        chk_all($sformatf("wrap%0d_rd%0d", p, k), word_t'(10 + 20 * p + k), (k == 9), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_16_8

// File: doc/fifo_16_8.md
Name: fifo_16_8

Overview:
- Synchronous single-clock FIFO buffer, 16 entries deep and 8 bits wide.
- Writes and reads use independent enables.
- Registered read data output.
- Provides empty and full status flags for a producer/consumer pair in the same clock domain.

Parameters:
- width, 8, data word width in bits
- depth, 16, number of storage entries (must equal 2**addr_size)
- addr_size, 4, address width for storage indexing

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous reset, active-low; clears pointers, flags and data_out
- data_in  input  width  write data, sampled on rising clk when a write is accepted
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_out  output  width  read data register
- empty  output  1  high when FIFO holds zero entries
- full  output  1  high when FIFO holds depth entries

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0, any time, independent of clk):
  - wr_ptr=0, rd_ptr=0, data_out=0, empty=1, full=0.
  - Storage array is not cleared.
  - Reset mid-operation discards all stored entries.
- Pointers are addr_size+1 bits (5 bits).
  - Lower addr_size bits index storage.
  - MSB is the wrap bit.
  - Both pointers wrap naturally modulo 2*depth.
- Flags are combinational from the pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[addr_size] != rd_ptr[addr_size]) and (lower bits equal).
- Write accept condition: wr_en=1 and full=0, using pre-edge flag values.
  - On accept: mem[wr_ptr[addr_size-1:0]] <= data_in; wr_ptr increments by 1.
  - Write while full: ignored; pointer and storage unchanged.
- Read accept condition: rd_en=1 and empty=0, using pre-edge flag values.
  - On accept: data_out <= mem[rd_ptr[addr_size-1:0]]; rd_ptr increments by 1.
  - Read while empty: ignored; data_out holds its previous value.
- Read latency: data_out shows the oldest entry one rising edge after the accepted read (registered output).
- data_out holds its value whenever no read is accepted.
- Simultaneous wr_en and rd_en:
  - Each is evaluated independently against the pre-edge flags.
  - Non-full, non-empty: both occur; occupancy unchanged.
  - When full: read only (full deasserts).
  - When empty: write only (no same-cycle bypass; data_out unchanged, empty deasserts).
- Held enables: a continuously asserted wr_en writes one word per cycle until full.
  - A continuously asserted rd_en reads one word per cycle until empty.
- Ordering: strict first-in first-out; values leave in write order across wrap-around.

Decomposition:
- Shared package fifo_pkg holds:
  - constants FIFO_WIDTH=8, FIFO_DEPTH=16, FIFO_ADDR_SIZE=4;
  - typedef for the data word;
  - typedef for the (addr_size+1)-bit pointer.
- One sub-module is natural: fifo_mem, a depth x width register array with one synchronous write port and one synchronous read port (registered output).
- Pointer/flag logic stays in fifo_16_8.

Test Plan:
- Reset: drive rst=0 for one cycle then rst=1 -> empty=1, full=0, data_out=0.
- Fill: write 101..116 on 16 consecutive cycles -> empty drops after the first edge; full=1 after the 16th write. A 17th write of 200 is ignored and full stays 1.
- Drain with held rd_en:
  - first output data_out=101 one edge after the first read cycle, and full=0 after that edge;
  - subsequent cycles give 102, 103, ... in order;
  - after 116 is read, empty=1 and data_out holds 116 while rd_en stays high.
- Reset mid-operation: with 5 entries stored, pulse rst low asynchronously between clock edges -> immediately empty=1, full=0, data_out=0. Then write 160 and read once -> data_out=160, empty=1.
- Simultaneous access:
  - with 3 entries, wr_en=rd_en=1 for one cycle -> occupancy stays 3, data_out=oldest entry;
  - at full, both asserted -> read only, full=0;
  - at empty, both asserted -> write only, data_out unchanged, empty=0.
- Wrap-around: repeat fill/drain of 10 entries three times -> pointers cross the index-15 boundary, and data order and flags stay correct each pass.
